drive_mode_ctrl: RTL and testbench

//  Top-level robot drive-mode controller. Decodes IR remote codes into IDLE/CAM/IR modes.
//  In CAM mode it runs a search/follow/lost/give-up sub-FSM on the camera tracker output.

---
 rtl/drive_pkg.sv | 49 ++++
 rtl/timeout_ctr.sv | 34 +++
 rtl/drive_mode_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_drive_mode_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drive_pkg
// Purpose  : Shared types, default IR button codes and timing helper for the
//            robot drive-mode controller.
// Revision : 1.0 - initial release
// ============================================================================
package drive_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_CAM  = 2'd1,
    MODE_IR   = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    CS_SEARCH = 3'd0,
    CS_FOLLOW = 3'd1,
    CS_LOST   = 3'd2,
    CS_PAUSE  = 3'd3,
    CS_GIVEUP = 3'd4
  } cam_state_t;

  typedef enum logic [1:0] {
    DIR_STOP  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_FWD   = 2'd3
  } drive_dir_t;

  localparam logic [7:0] BTN_CAM_CODE   = 8'h0F;
  localparam logic [7:0] BTN_IR_CODE    = 8'h13;
  localparam logic [7:0] BTN_IDLE_CODE  = 8'h10;
  localparam logic [7:0] BTN_FWD_CODE   = 8'h18;
  localparam logic [7:0] BTN_LEFT_CODE  = 8'h08;
  localparam logic [7:0] BTN_RIGHT_CODE = 8'h5A;
  localparam logic [7:0] BTN_STOP_CODE  = 8'h1C;

  // Milliseconds to clock cycles; the product is formed in 64 bits because
  // 5000 ms at 50 MHz does not fit in 32. Never returns less than one cycle.
  function automatic int ms_to_cyc(input int ms, input int clk_hz);
    longint prod;
    prod = (longint'(ms) * longint'(clk_hz)) / 64'sd1000;
    if (prod < 64'sd1) prod = 64'sd1;
    return int'(prod);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : timeout_ctr
// Purpose  : Saturating cycle counter. done is high once MAX_CYC enabled
//            cycles have elapsed since the last clear (counter sits at
//            MAX_CYC-1 and never wraps).
// Revision : 1.0 - initial release
// ============================================================================
module timeout_ctr #(
  parameter int MAX_CYC = 16
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int              W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [W-1:0]    c_LAST = W'(MAX_CYC - 1);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, clear has priority, hold at the terminal value.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)                         r_cnt <= '0;
    else if (clr)                       r_cnt <= '0;
    else if (en && (r_cnt != c_LAST))   r_cnt <= r_cnt + 1'b1;
  end

  assign done = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/drive_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : drive_mode_ctrl
// Purpose  : IR-remote mode selection (IDLE/CAM/IR), camera search/follow
//            sub-FSM, registered drive command and downstream reset pulse.
// Revision : 1.0 - initial release
// ============================================================================
module drive_mode_ctrl
  import drive_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         N_SPEED   = 3,
  parameter int         LOST_MS   = 200,
  parameter int         SEARCH_MS = 5000,
  parameter int         RST_PULSE = 4,
  parameter logic [7:0] BTN_CAM   = BTN_CAM_CODE,
  parameter logic [7:0] BTN_IR    = BTN_IR_CODE,
  parameter logic [7:0] BTN_IDLE  = BTN_IDLE_CODE,
  parameter logic [7:0] BTN_FWD   = BTN_FWD_CODE,
  parameter logic [7:0] BTN_LEFT  = BTN_LEFT_CODE,
  parameter logic [7:0] BTN_RIGHT = BTN_RIGHT_CODE,
  parameter logic [7:0] BTN_STOP  = BTN_STOP_CODE,
  parameter int         IR_SPEED  = 1,
  localparam int        SW        = (N_SPEED > 1) ? $clog2(N_SPEED) : 1
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          ir_valid,
  input  logic [7:0]    ir_code,
  input  logic          cam_valid,
  input  logic [2:0]    cam_dir,
  input  logic [SW-1:0] cam_speed,
  output logic [1:0]    mode,
  output logic [2:0]    cam_state,
  output logic [1:0]    drive_dir,
  output logic [SW-1:0] drive_speed,
  output logic          sub_reset,
  output logic          search_to
);

  localparam logic [1:0] c_MODE_IDLE = MODE_IDLE;
  localparam logic [1:0] c_MODE_CAM  = MODE_CAM;
  localparam logic [1:0] c_MODE_IR   = MODE_IR;

  localparam logic [2:0] c_CS_SEARCH = CS_SEARCH;
  localparam logic [2:0] c_CS_FOLLOW = CS_FOLLOW;
  localparam logic [2:0] c_CS_LOST   = CS_LOST;
  localparam logic [2:0] c_CS_PAUSE  = CS_PAUSE;
  localparam logic [2:0] c_CS_GIVEUP = CS_GIVEUP;

  localparam logic [1:0] c_DIR_STOP  = DIR_STOP;
  localparam logic [1:0] c_DIR_LEFT  = DIR_LEFT;
  localparam logic [1:0] c_DIR_RIGHT = DIR_RIGHT;
  localparam logic [1:0] c_DIR_FWD   = DIR_FWD;

  localparam int              c_SEARCH_CYC = ms_to_cyc(SEARCH_MS, CLK_HZ);
  localparam int              c_LOST_CYC   = ms_to_cyc(LOST_MS, CLK_HZ);
  localparam int              c_PW         = $clog2(RST_PULSE + 1);
  localparam logic [c_PW-1:0] c_PULSE      = c_PW'(RST_PULSE);
  localparam logic [SW-1:0]   c_SPEED_MAX  = SW'(N_SPEED - 1);
  localparam logic [SW-1:0]   c_IR_SPEED   = SW'(IR_SPEED);

  logic [1:0]      r_mode, w_mode_next;
  logic [2:0]      r_cam_state, w_cam_next;
  logic [1:0]      r_drive_dir, w_dir_next;
  logic [SW-1:0]   r_drive_speed, w_speed_next, w_cam_speed_sat;
  logic [c_PW-1:0] r_pulse_cnt;
  logic            w_det, w_cam_cmd, w_cam_change, w_any_change;
  logic            w_search_done, w_lost_done;

  // A frame counts as a detection only for the three defined directions.
  assign w_det     = cam_valid && ((cam_dir == 3'b001) || (cam_dir == 3'b010) ||
                                   (cam_dir == 3'b011));
  assign w_cam_cmd = ir_valid && (ir_code == BTN_CAM);
  assign w_cam_speed_sat = (int'(cam_speed) > (N_SPEED - 1)) ? c_SPEED_MAX : cam_speed;

  // Mode selection: only the three mode buttons move the mode register.
  always_comb begin
    w_mode_next = r_mode;
    if (ir_valid) begin
      if (ir_code == BTN_CAM)       w_mode_next = c_MODE_CAM;
      else if (ir_code == BTN_IR)   w_mode_next = c_MODE_IR;
      else if (ir_code == BTN_IDLE) w_mode_next = c_MODE_IDLE;
    end
  end

  // Camera sub-FSM; a mode command overrides detections and timeouts, and a
  // BTN_CAM press always (re)starts the search.
  always_comb begin
    w_cam_next = r_cam_state;
    if (w_mode_next != c_MODE_CAM) begin
      w_cam_next = c_CS_PAUSE;
    end else if (w_cam_cmd) begin
      w_cam_next = c_CS_SEARCH;
    end else begin
      case (r_cam_state)
        c_CS_SEARCH: begin
          if (w_det)              w_cam_next = c_CS_FOLLOW;
          else if (w_search_done) w_cam_next = c_CS_GIVEUP;
        end
        c_CS_FOLLOW: begin
          if (cam_valid)          w_cam_next = w_det ? c_CS_FOLLOW : c_CS_LOST;
          else if (w_lost_done)   w_cam_next = c_CS_LOST;
        end
        c_CS_LOST: begin
          if (w_det)              w_cam_next = c_CS_FOLLOW;
          else if (w_lost_done)   w_cam_next = c_CS_SEARCH;
        end
        c_CS_GIVEUP:              w_cam_next = c_CS_GIVEUP;
        default:                  w_cam_next = c_CS_SEARCH;
      endcase
    end
  end

  assign w_cam_change = (w_cam_next != r_cam_state) || w_cam_cmd;
  assign w_any_change = w_cam_change || (w_mode_next != r_mode);

  // Search timer runs only while searching and restarts on any state entry.
  timeout_ctr #(.MAX_CYC(c_SEARCH_CYC)) u_search_tmr (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .clr    (w_cam_change),
    .en     (r_cam_state == c_CS_SEARCH),
    .done   (w_search_done)
  );

  // One timer serves both the stale-frame check in FOLLOW (restarted by
  // every frame) and the fallback delay in LOST.
  timeout_ctr #(.MAX_CYC(c_LOST_CYC)) u_lost_tmr (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .clr    (w_cam_change || ((r_cam_state == c_CS_FOLLOW) && cam_valid)),
    .en     ((r_cam_state == c_CS_FOLLOW) || (r_cam_state == c_CS_LOST)),
    .done   (w_lost_done)
  );

  // Drive command for the state being entered; IR keeps its latched command
  // and FOLLOW keeps the last detected direction between frames.
  always_comb begin
    w_dir_next   = c_DIR_STOP;
    w_speed_next = '0;
    if (w_mode_next == c_MODE_IR) begin
      if (r_mode == c_MODE_IR) begin
        w_dir_next   = r_drive_dir;
        w_speed_next = r_drive_speed;
        if (ir_valid) begin
          if (ir_code == BTN_FWD) begin
            w_dir_next   = c_DIR_FWD;
            w_speed_next = c_IR_SPEED;
          end else if (ir_code == BTN_LEFT) begin
            w_dir_next   = c_DIR_LEFT;
            w_speed_next = '0;
          end else if (ir_code == BTN_RIGHT) begin
            w_dir_next   = c_DIR_RIGHT;
            w_speed_next = '0;
          end else if (ir_code == BTN_STOP) begin
            w_dir_next   = c_DIR_STOP;
            w_speed_next = '0;
          end
        end
      end
    end else if (w_mode_next == c_MODE_CAM) begin
      if (w_cam_next == c_CS_SEARCH) begin
        w_dir_next = c_DIR_RIGHT;
      end else if (w_cam_next == c_CS_FOLLOW) begin
        if (w_det) begin
          case (cam_dir)
            3'b001:  w_dir_next = c_DIR_LEFT;
            3'b010:  w_dir_next = c_DIR_RIGHT;
            default: begin
              w_dir_next   = c_DIR_FWD;
              w_speed_next = w_cam_speed_sat;
            end
          endcase
        end else begin
          w_dir_next   = r_drive_dir;
          w_speed_next = r_drive_speed;
        end
      end
    end
  end

  // State and drive registers.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= c_MODE_IDLE;
      r_cam_state   <= c_CS_PAUSE;
      r_drive_dir   <= c_DIR_STOP;
      r_drive_speed <= '0;
    end else begin
      r_mode        <= w_mode_next;
      r_cam_state   <= w_cam_next;
      r_drive_dir   <= w_dir_next;
      r_drive_speed <= w_speed_next;
    end
  end

  // Downstream reset pulse: loaded on reset and on every change, then drains.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)                 r_pulse_cnt <= c_PULSE;
    else if (w_any_change)      r_pulse_cnt <= c_PULSE;
    else if (r_pulse_cnt != '0) r_pulse_cnt <= r_pulse_cnt - 1'b1;
  end

  assign mode        = r_mode;
  assign cam_state   = r_cam_state;
  assign drive_dir   = r_drive_dir;
  assign drive_speed = r_drive_speed;
  assign sub_reset   = (r_pulse_cnt != '0);
  assign search_to   = (r_cam_state == c_CS_GIVEUP);

endmodule
`default_nettype wire

// File: tb/tb_drive_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_drive_mode_ctrl
// Purpose  : Directed scoreboard bench for drive_mode_ctrl at CLK_HZ=1000
//            (1 ms = 1 cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_drive_mode_ctrl;

  logic       clk_50    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ir_valid  = 1'b0;
  logic [7:0] ir_code   = 8'h00;
  logic       cam_valid = 1'b0;
  logic [2:0] cam_dir   = 3'b000;
  logic [1:0] cam_speed = 2'd0;
  logic [1:0] mode;
  logic [2:0] cam_state;
  logic [1:0] drive_dir;
  logic [1:0] drive_speed;
  logic       sub_reset;
  logic       search_to;

  drive_mode_ctrl #(.CLK_HZ(1000)) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .ir_valid    (ir_valid),
    .ir_code     (ir_code),
    .cam_valid   (cam_valid),
    .cam_dir     (cam_dir),
    .cam_speed   (cam_speed),
    .mode        (mode),
    .cam_state   (cam_state),
    .drive_dir   (drive_dir),
    .drive_speed (drive_speed),
    .sub_reset   (sub_reset),
    .search_to   (search_to)
  );

  always #5 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [2:0] cs;
    logic [1:0] dir;
    logic [1:0] spd;
    logic       sr;
    logic       sto;
  } exp_t;

  exp_t  sb[$];
  string nm[$];
  int    checks = 0;
  int    errors = 0;

  // Queue the outputs expected to be visible during the current cycle.
  task automatic push_exp(input string name, input logic [1:0] m, input logic [2:0] cs,
                          input logic [1:0] d, input logic [1:0] s, input logic sr,
                          input logic sto);
    exp_t e;
    e.cyc = cyc; e.mode = m; e.cs = cs; e.dir = d; e.spd = s; e.sr = sr; e.sto = sto;
    sb.push_back(e);
    nm.push_back(name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic ir_key(input logic [7:0] code);
    ir_valid = 1'b1;
    ir_code  = code;
    tick(1);
    ir_valid = 1'b0;
    ir_code  = 8'h00;
  endtask

  task automatic cam_frame(input logic [2:0] d, input logic [1:0] s);
    cam_valid = 1'b1;
    cam_dir   = d;
    cam_speed = s;
    tick(1);
    cam_valid = 1'b0;
    cam_dir   = 3'b000;
    cam_speed = 2'd0;
  endtask

  // Monitor: compares every expectation due in this cycle at the falling edge.
  always @(negedge clk_50) begin
    exp_t  e;
    string n;
    while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
      e = sb.pop_front();
      n = nm.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d left unchecked at cycle %0d", n, e.cyc, cyc);
      end else if ({mode, cam_state, drive_dir, drive_speed, sub_reset, search_to} !==
                   {e.mode, e.cs, e.dir, e.spd, e.sr, e.sto}) begin
        errors++;
        $display("FAIL %s: got mode=%0d cs=%0d dir=%0d spd=%0d sr=%0d sto=%0d, expected mode=%0d cs=%0d dir=%0d spd=%0d sr=%0d sto=%0d",
                 n, mode, cam_state, drive_dir, drive_speed, sub_reset, search_to,
                 e.mode, e.cs, e.dir, e.spd, e.sr, e.sto);
      end
    end
  end

  initial begin
    // Reset: held three cycles, then a four-cycle sub_reset tail.
    tick(3);
    push_exp("reset_hold", 2'd0, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      push_exp("reset_pulse", 2'd0, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0);
    end
    tick(1);
    push_exp("reset_pulse_end", 2'd0, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0);

    // Enter CAM, search, unknown code ignored.
    ir_key(8'h0F);
    push_exp("cam_entry", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    tick(3);
    push_exp("cam_pulse_hold", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    tick(1);
    push_exp("cam_pulse_end", 2'd1, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    ir_key(8'h42);
    push_exp("unknown_code", 2'd1, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0);

    // Follow: forward, left, saturated speed.
    cam_frame(3'b011, 2'd2);
    push_exp("follow_fwd", 2'd1, 3'd1, 2'd3, 2'd2, 1'b1, 1'b0);
    cam_frame(3'b001, 2'd2);
    push_exp("follow_left", 2'd1, 3'd1, 2'd1, 2'd0, 1'b1, 1'b0);
    cam_frame(3'b011, 2'd3);
    push_exp("follow_speed_sat", 2'd1, 3'd1, 2'd3, 2'd2, 1'b1, 1'b0);

    // Stale frames -> LOST -> det exactly on the lost expiry cycle.
    tick(199);
    push_exp("follow_hold", 2'd1, 3'd1, 2'd3, 2'd2, 1'b0, 1'b0);
    tick(1);
    push_exp("stale_to_lost", 2'd1, 3'd2, 2'd0, 2'd0, 1'b1, 1'b0);
    tick(199);
    push_exp("lost_hold", 2'd1, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    cam_frame(3'b010, 2'd0);
    push_exp("det_beats_lost_to", 2'd1, 3'd1, 2'd2, 2'd0, 1'b1, 1'b0);

    // Frame without detection -> LOST -> SEARCH after 200 cycles.
    cam_frame(3'b111, 2'd1);
    push_exp("nodet_frame_lost", 2'd1, 3'd2, 2'd0, 2'd0, 1'b1, 1'b0);
    tick(199);
    push_exp("lost_hold2", 2'd1, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    tick(1);
    push_exp("lost_to_search", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);

    // Fruitless search -> GIVEUP, then BTN_CAM restarts.
    tick(4999);
    push_exp("search_hold", 2'd1, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    tick(1);
    push_exp("giveup", 2'd1, 3'd4, 2'd0, 2'd0, 1'b1, 1'b1);
    tick(4);
    push_exp("giveup_hold", 2'd1, 3'd4, 2'd0, 2'd0, 1'b0, 1'b1);
    ir_key(8'h0F);
    push_exp("giveup_restart", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    tick(4);
    push_exp("restart_pulse_end", 2'd1, 3'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    ir_key(8'h0F);
    push_exp("search_reentry", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);

    // IR mode drive latch.
    ir_key(8'h13);
    push_exp("ir_entry", 2'd2, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0);
    ir_key(8'h18);
    push_exp("ir_fwd", 2'd2, 3'd3, 2'd3, 2'd1, 1'b1, 1'b0);
    ir_key(8'h08);
    push_exp("ir_left", 2'd2, 3'd3, 2'd1, 2'd0, 1'b1, 1'b0);
    ir_key(8'h42);
    push_exp("ir_hold", 2'd2, 3'd3, 2'd1, 2'd0, 1'b1, 1'b0);
    ir_key(8'h5A);
    push_exp("ir_right", 2'd2, 3'd3, 2'd2, 2'd0, 1'b0, 1'b0);
    ir_key(8'h1C);
    push_exp("ir_stop", 2'd2, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0);
    ir_key(8'h18);
    push_exp("ir_fwd2", 2'd2, 3'd3, 2'd3, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-drive: visible before the next rising edge.
    tick(1);
    rst_n = 1'b0;
    push_exp("async_reset", 2'd0, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0);
    tick(2);
    push_exp("reset_held", 2'd0, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(4);
    push_exp("post_reset", 2'd0, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0);

    // Drive codes ignored in CAM, then back to IDLE.
    ir_key(8'h0F);
    push_exp("cam_again", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    ir_key(8'h1C);
    push_exp("cam_ignores_stop", 2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0);
    ir_key(8'h10);
    push_exp("cam_to_idle", 2'd0, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0);

    tick(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
